// File: rtl/timer_pkg.sv
// timer_pkg: state encoding and BCD digit limits shared by the mm:ss countdown timer.
package timer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
    localparam logic [3:0] DIGIT_MAX_UNIT     = 4'd9;
    localparam logic [3:0] DIGIT_MAX_SEC_TENS = 4'd5;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD down-counter digit; wraps 0 -> MAX with a borrow to the next digit.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_UNIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       borrow_out
);
    logic [3:0] value_q;
    logic [3:0] value_d;
    always_comb begin
        value_d = load ? ((load_val > MAX) ? MAX : load_val)
                : en   ? ((value_q == 4'd0) ? MAX : value_q - 4'd1)
                : value_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= 4'd0;
        else     value_q <= value_d;
    end
    assign value      = value_q;
    assign borrow_out = en && (value_q == 4'd0);
endmodule

// File: rtl/mmss_countdown_timer.sv
// mmss_countdown_timer: mm:ss BCD countdown with a one-second prescaler and IDLE/RUN/PAUSED/DONE control.
module mmss_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int PRESC_W  = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_minute_tens,
    input  logic [3:0] load_minute_unit,
    input  logic [3:0] load_second_tens,
    input  logic [3:0] load_second_unit,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] second_unit,
    output logic [3:0] second_tens,
    output logic [3:0] minute_unit,
    output logic [3:0] minute_tens,
    output logic       running,
    output logic       done
);
    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 running_q, done_q;
    logic                 last, tick, digit_ld, is_zero, is_one;
    logic                 b_su, b_st, b_mu, b_mt;
    logic [3:0]           ld_mt, ld_mu, ld_st, ld_su;

    assign last     = presc_q == PRESC_W'(TICK_DIV - 1);
    assign tick     = (state_q == ST_RUN) && last && !clear && !pause;
    assign digit_ld = clear || (load && state_q != ST_RUN);
    assign is_zero  = {minute_tens, minute_unit, second_tens, second_unit} == 16'h0000;
    assign is_one   = {minute_tens, minute_unit, second_tens, second_unit} == 16'h0001;
    assign ld_mt    = clear ? 4'd0 : load_minute_tens;
    assign ld_mu    = clear ? 4'd0 : load_minute_unit;
    assign ld_st    = clear ? 4'd0 : load_second_tens;
    assign ld_su    = clear ? 4'd0 : load_second_unit;

    bcd_digit_down #(.MAX(DIGIT_MAX_UNIT)) u_su (
        .clk(clk), .rst(rst), .en(tick), .load(digit_ld), .load_val(ld_su),
        .value(second_unit), .borrow_out(b_su)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX_SEC_TENS)) u_st (
        .clk(clk), .rst(rst), .en(b_su), .load(digit_ld), .load_val(ld_st),
        .value(second_tens), .borrow_out(b_st)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX_UNIT)) u_mu (
        .clk(clk), .rst(rst), .en(b_st), .load(digit_ld), .load_val(ld_mu),
        .value(minute_unit), .borrow_out(b_mu)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX_UNIT)) u_mt (
        .clk(clk), .rst(rst), .en(b_mu), .load(digit_ld), .load_val(ld_mt),
        .value(minute_tens), .borrow_out(b_mt)
    );

    // Priority clear > load > pause > start; pause also masks start outside RUN.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (clear || (load && state_q != ST_RUN)) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            state_d = pause ? ST_PAUSED : (tick && is_one) ? ST_DONE : ST_RUN;
            presc_d = pause ? presc_q : last ? '0 : presc_q + PRESC_W'(1);
        end else if (!pause && start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
            state_d = is_zero ? ST_DONE : ST_RUN;
            presc_d = (state_q == ST_IDLE) ? '0 : presc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= state_d == ST_RUN;
            done_q    <= state_d == ST_DONE;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    logic unused_borrow;
    assign unused_borrow = b_mt;
endmodule

// File: tb/tb_mmss_countdown_timer.sv
// tb_mmss_countdown_timer: scoreboard bench; a seconds-count reference model predicts every cycle's outputs.
module tb_mmss_countdown_timer;
    localparam int TD = 4;
    logic clk = 0, rst = 1, clear = 0, load = 0, start = 0, pause = 0;
    logic [3:0] l_mt = 0, l_mu = 0, l_st = 0, l_su = 0;
    logic [3:0] second_unit, second_tens, minute_unit, minute_tens;
    logic running, done;
    int errors = 0, checks = 0;

    typedef struct {
        logic [15:0] d;
        logic        r;
        logic        dn;
        string       tag;
    } exp_t;
    exp_t q[$];

    // reference model: remaining time as plain seconds, mode 0 idle 1 run 2 paused 3 done
    int m_tot = 0, m_mode = 0, m_pr = 0;

    mmss_countdown_timer #(.TICK_DIV(TD), .PRESC_W(3)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_minute_tens(l_mt), .load_minute_unit(l_mu),
        .load_second_tens(l_st), .load_second_unit(l_su),
        .start(start), .pause(pause),
        .second_unit(second_unit), .second_tens(second_tens),
        .minute_unit(minute_unit), .minute_tens(minute_tens),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int mn(input int a, input int b);
        return a < b ? a : b;
    endfunction

    task automatic step(input logic c, input logic l, input logic [15:0] v,
                        input logic s, input logic p, input string tag);
        exp_t e;
        @(negedge clk);
        clear = c; load = l; start = s; pause = p;
        {l_mt, l_mu, l_st, l_su} = v;
        if (c) begin
            m_mode = 0; m_tot = 0; m_pr = 0;
        end else if (l && m_mode != 1) begin
            m_tot = (mn(int'(v[15:12]), 9) * 10 + mn(int'(v[11:8]), 9)) * 60
                  + mn(int'(v[7:4]), 5) * 10 + mn(int'(v[3:0]), 9);
            m_mode = 0; m_pr = 0;
        end else if (m_mode == 1) begin
            if (p) m_mode = 2;
            else if (m_pr == TD - 1) begin
                m_pr = 0;
                m_tot = m_tot - 1;
                if (m_tot == 0) m_mode = 3;
            end else m_pr = m_pr + 1;
        end else if (!p && s && (m_mode == 0 || m_mode == 2)) begin
            if (m_mode == 0) m_pr = 0;
            m_mode = (m_tot == 0) ? 3 : 1;
        end
        e.d = to_bcd(m_tot);
        e.r = m_mode == 1;
        e.dn = m_mode == 3;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, tag);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({minute_tens, minute_unit, second_tens, second_unit, running, done} != 18'h0) begin
            errors++;
            $display("FAIL async_reset: got %h run=%b done=%b, expected 0000 run=0 done=0",
                     {minute_tens, minute_unit, second_tens, second_unit}, running, done);
        end
        #1;
        rst = 0;
        clear = 0; load = 0; start = 0; pause = 0;
        m_mode = 0; m_tot = 0; m_pr = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({minute_tens, minute_unit, second_tens, second_unit} !== e.d ||
                    running !== e.r || done !== e.dn) begin
                    errors++;
                    $display("FAIL %s: got %h run=%b done=%b, expected %h run=%b done=%b", e.tag,
                             {minute_tens, minute_unit, second_tens, second_unit}, running, done,
                             e.d, e.r, e.dn);
                end
            end
        end
    end

    initial begin : driver
        logic [15:0] v;
        #12 rst = 0;
        step(0, 1, 16'h1234, 0, 0, "load_1234");
        idle(2, "idle_1234");
        step(0, 0, 16'h0, 1, 0, "start_1234");
        idle(5, "run_1234");
        reset_mid();
        step(0, 1, 16'h1234, 0, 0, "reload_1234");
        idle(1, "idle_after_reload");
        step(0, 1, 16'h1000, 0, 0, "load_1000");
        step(0, 0, 16'h0, 1, 0, "start_1000");
        idle(9, "borrow_chain");
        step(0, 1, 16'h0002, 0, 0, "load_0002");
        step(0, 0, 16'h0, 1, 0, "start_0002");
        idle(17, "terminal_count");
        step(0, 1, 16'h0100, 0, 0, "load_0100");
        step(0, 0, 16'h0, 1, 0, "start_0100");
        idle(2, "run_0100");
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 0, 1, "paused_0100");
        step(0, 0, 16'h0, 1, 0, "resume_0100");
        idle(3, "after_resume");
        step(0, 1, 16'h0505, 0, 0, "load_in_run");
        idle(4, "run_after_load");
        step(1, 1, 16'h0505, 0, 0, "clear_with_load");
        idle(1, "idle_after_clear");
        step(0, 1, 16'h0005, 0, 0, "load_0005");
        step(0, 0, 16'h0, 1, 0, "start_0005");
        idle(3, "run_0005");
        step(0, 0, 16'h0, 0, 1, "pause_on_tick");
        idle(2, "paused_0005");
        step(0, 0, 16'h0, 1, 0, "resume_0005");
        idle(5, "run_0005b");
        step(1, 0, 16'h0, 0, 0, "clear_run");
        step(0, 0, 16'h0, 1, 0, "start_zero");
        step(0, 0, 16'h0, 1, 0, "start_in_done");
        step(0, 0, 16'h0, 0, 1, "pause_in_done");
        step(0, 1, 16'h007c, 0, 0, "load_saturate");
        step(0, 1, 16'hffff, 0, 0, "load_saturate_all");
        step(0, 1, 16'h0, 0, 0, "load_zero");
        step(0, 0, 16'h0, 1, 0, "start_zero2");
        step(1, 0, 16'h0, 0, 0, "clear_in_done");
        for (int i = 0; i < 3000; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1) v[15:8] = 8'h0;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, v,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6, "random");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmss_countdown_timer.md
Name: mmss_countdown_timer

Overview:
- Upstream stage of the 4-digit seven-segment display path.
- Holds a minutes:seconds value as four BCD digits and counts it down once per second.
- Second timing comes from an internal prescaler on the system clock.
- Its four BCD digit outputs connect directly to the 4-digit decoder stage. Run/pause/done status goes to control logic and LEDs.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick (minimum 2; benches use 4).
- PRESC_W, 26, prescaler counter width; must satisfy 2**PRESC_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous clear pulse.
- load  in  1  synchronous load pulse.
- load_minute_tens  in  4  BCD digit captured on load.
- load_minute_unit  in  4  BCD digit captured on load.
- load_second_tens  in  4  BCD digit captured on load.
- load_second_unit  in  4  BCD digit captured on load.
- start  in  1  start/resume request, level sampled each cycle.
- pause  in  1  pause request, level sampled each cycle.
- second_unit  out  4  BCD, 0-9.
- second_tens  out  4  BCD, 0-5.
- minute_unit  out  4  BCD, 0-9.
- minute_tens  out  4  BCD, 0-9.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- rst forces state IDLE, all four digits 0, prescaler 0, running 0, done 0.
- All outputs are registered. Digits and flags change only on a clk rising edge.

State machine:
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle input priority: clear > load > pause > start.
- clear, any state: go to IDLE; digits 0; prescaler 0.
- load in IDLE, PAUSED or DONE: capture digits; go to IDLE; prescaler 0.
- load in RUN: ignored.
- Load digit saturation: units above 9 become 9; second_tens above 5 becomes 5; minute_tens above 9 becomes 9.
- start in IDLE or PAUSED, digits non-zero: go to RUN.
- start in IDLE or PAUSED, digits 00:00: go to DONE.
- start from IDLE zeroes the prescaler. Resume from PAUSED keeps the prescaler value.
- pause in RUN: go to PAUSED; prescaler frozen.
- start or pause in DONE: ignored. Only clear or load leave DONE.

Prescaler and tick:
- Prescaler advances only in RUN and wraps TICK_DIV-1 -> 0.
- tick is internal and combinational: it is high in the RUN cycle where the prescaler equals TICK_DIV-1.
- The first decrement after start from IDLE occurs exactly TICK_DIV cycles after the start cycle.

Decrement (on tick):
- BCD borrow chain.
- second_unit 0 -> 9, with borrow; otherwise minus 1.
- second_tens 0 -> 5, with borrow; otherwise minus 1.
- minute_unit 0 -> 9, with borrow; otherwise minus 1.
- minute_tens minus 1.
- If the decremented value is 00:00, enter DONE on the same edge the digits update; running falls and done rises together.
- Digits hold 00:00 in DONE, with no underflow.

Simultaneous events:
- A pause asserted in the tick cycle wins: no decrement occurs.
- A clear asserted in the tick cycle wins over decrement and over DONE entry.
- Reset mid-count returns to reset values immediately, with no clock required.

Maximum value:
- 99:59 is the largest value.
- 10:00 -> 09:59 on one tick.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE (2 bits);
  - BCD limits DIGIT_MAX_UNIT=9 and DIGIT_MAX_SEC_TENS=5.
- One natural sub-module: bcd_digit_down. It is a single 4-bit BCD down-counter digit with parameter MAX, inputs en, load and load_val, and outputs value and borrow_out. It is instantiated four times as a cascade.
- The prescaler and the FSM stay in the top module.

Test Plan (TICK_DIV=4):
- Reset and load: assert rst mid-simulation -> all digits 0, running=0, done=0 asynchronously. Then load 12:34 -> outputs 1,2,3,4 on the next edge; state IDLE.
- Borrow chain: load 10:00, start -> exactly 4 cycles later digits 09:59. Then 4 cycles after that -> 09:58.
- Terminal count: load 00:02, start -> 00:01 after 4 cycles. 4 cycles later, 00:00 with done=1 and running=0 on the same edge. After 8 more cycles the digits remain 00:00.
- Pause and resume: load 01:00, start, pause at prescaler=2 for 10 cycles -> digits stay 01:00. Release pause and assert start -> 00:59 exactly 2 cycles after resume.
- Priority and ignore rules:
  - load during RUN -> ignored;
  - clear with load in the same cycle -> IDLE at 00:00;
  - pause coinciding with tick -> no decrement;
  - start with 00:00 loaded -> DONE next edge.
- Saturation: load with second_tens=7 and second_unit=12 -> captured as 5 and 9. Then clear in DONE -> IDLE, done=0.
